// File: rtl/ins_loader.sv
// Framed byte-stream program loader: parses SYNC/LEN/payload/CHK frames from
// a valid/ready byte source and writes the payload into instruction memory
// through its injection port, holding the CPU in reset until the frame verifies.
module ins_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_BYTES  = 1024,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] inject_addr,
    output logic [7:0]            inject_data,
    output logic                  inject_clock,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned LEN_W = 16;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_BYTES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WSTB,
        S_WEND,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q;
    logic                    rx_ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              data_q;
    logic                    strobe_q;
    logic                    cpu_reset_q;
    logic                    done_q;
    logic                    error_q;
    logic [CNT_W-1:0]        count_q;
    logic [LEN_W-1:0]        len_q;
    logic [7:0]              sum_q;

    logic                    xfer;
    logic                    is_sync;
    logic [CNT_W-1:0]        count_d;
    logic [LEN_W-1:0]        len_d;
    logic [7:0]              sum_d;

    // Handshake decode and next values of the frame counters.
    assign xfer    = rx_valid & rx_ready_q;
    assign is_sync = (rx_data == SYNC_BYTE);
    assign count_d = count_q + CNT_W'(1);
    assign len_d   = {rx_data, len_q[7:0]};
    assign sum_d   = sum_q + rx_data;

    // Frame parser and write sequencer; every output is a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
            sum_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer && is_sync) begin
                        state_q <= S_LEN_LO;
                        count_q <= '0;
                        sum_q   <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        len_q   <= {8'h00, rx_data};
                        state_q <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len_q <= len_d;
                        if (len_d > MAX_LEN) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (len_d == '0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    // Address and data settle a full cycle ahead of the strobe.
                    if (xfer) begin
                        addr_q     <= count_q[ADDR_WIDTH-1:0];
                        data_q     <= rx_data;
                        sum_q      <= sum_d;
                        rx_ready_q <= 1'b0;
                        state_q    <= S_WSTB;
                    end
                end

                S_WSTB: begin
                    strobe_q <= 1'b1;
                    state_q  <= S_WEND;
                end

                S_WEND: begin
                    strobe_q   <= 1'b0;
                    count_q    <= count_d;
                    rx_ready_q <= 1'b1;
                    if (LEN_W'(count_d) == len_q) begin
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_DATA;
                    end
                end

                S_CHECK: begin
                    if (xfer) begin
                        if (sum_d == 8'h00) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    // A new sync byte restarts loading; anything else is dropped.
                    if (xfer && is_sync) begin
                        state_q     <= S_LEN_LO;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        count_q     <= '0;
                        sum_q       <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign inject_addr  = addr_q;
    assign inject_data  = data_q;
    assign inject_clock = strobe_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign byte_count   = count_q;

endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
Byte-stream program loader that sits directly upstream of the instruction memory and drives its injection port (inject_addr, inject_data, inject_clock). It parses framed bytes from the UART receiver using a valid/ready handshake, then writes the payload sequentially from address 0. It holds the CPU in reset until a frame loads and its checksum verifies.

Parameters:
ADDR_WIDTH, 10, instruction memory byte-address width
MEM_BYTES, 1024, maximum payload length accepted
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready at posedge)
inject_addr  output  ADDR_WIDTH  byte address to instruction memory
inject_data  output  8  byte to write
inject_clock  output  1  write strobe; memory writes on its rising edge
cpu_reset  output  1  holds CPU in reset while high
load_done  output  1  frame loaded and checksum verified
load_error  output  1  frame rejected
byte_count  output  ADDR_WIDTH+1  payload bytes written in current frame

Behaviour:
- Frame: SYNC_BYTE, LEN_LO, LEN_HI (16-bit little-endian length), LEN payload bytes, CHK. CHK is chosen so that (sum of payload bytes + CHK) mod 256 == 0.
- Reset values: state IDLE, rx_ready 1, inject_addr 0, inject_data 0, inject_clock 0, cpu_reset 1, load_done 0, load_error 0, byte_count 0, length and sum registers 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, WSTB, WEND, CHECK, DONE, ERROR.
- IDLE: a SYNC_BYTE transfer moves to LEN_LO and clears byte_count and the sum. Other bytes are consumed and discarded.
- LEN_LO: latch the low byte, then go to LEN_HI.
- LEN_HI: latch the high byte. Length > MEM_BYTES goes to ERROR. Length == 0 goes to CHECK. Otherwise go to DATA.
- DATA: on transfer at edge k, register inject_addr = byte_count[ADDR_WIDTH-1:0] and inject_data = rx_data, add rx_data to the sum, then go to WSTB.
- WSTB: inject_clock = 1 from edge k+1. Addr and data have been stable one full cycle before the rising edge.
- WEND: inject_clock = 0 from edge k+2 and byte_count increments. If byte_count equals length, go to CHECK, else go to DATA.
- rx_ready = 1 only in IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERROR. It is 0 in WSTB and WEND, so the maximum payload rate is one byte per 3 cycles.
- inject_addr and inject_data hold their last values outside writes. inject_clock is never high for two consecutive cycles.
- CHECK: on transfer, (sum + rx_data) mod 256 == 0 goes to DONE, otherwise ERROR.
- DONE: load_done = 1 and cpu_reset = 0 from the edge entering DONE.
- ERROR: load_error = 1 and cpu_reset stays 1. Bytes already written remain in memory.
- DONE or ERROR: a SYNC_BYTE transfer restarts the load. It clears load_done and load_error, sets cpu_reset = 1 and goes to LEN_LO, all on the same edge. Non-sync bytes are discarded.
- A rx_valid drop mid-frame simply stalls; there is no timeout.
- Reset in any state, including mid-write with inject_clock high, returns to reset values on the next edge. A partial frame is abandoned.
- The sum is 8-bit and wraps. byte_count is ADDR_WIDTH+1 bits, so it can reach MEM_BYTES. inject_addr wraps naturally only at MEM_BYTES, which is never exceeded.

Test Plan:
- Basic load: frame A5,04,00,13,00,00,00,ED -> four inject_clock pulses writing 0x13,0x00,0x00,0x00 at addr 0..3. load_done=1, cpu_reset=0, byte_count=4.
- Bad checksum: same frame with CHK=EE -> four writes occur, then load_error=1, cpu_reset=1, load_done=0.
- Zero and oversize length: A5,00,00,00 -> DONE with no inject_clock pulse. A5,01,04 (length 1025) -> ERROR immediately, no writes.
- Strobe timing: assert rx_valid continuously during the payload -> rx_ready low exactly 2 cycles after each data byte. inject_clock high for 1 cycle, with addr/data changing only on the edge before the pulse.
- Garbage and restart: 00,FF before A5 are discarded. After DONE, send A5 -> cpu_reset=1 and load_done=0 on that edge; a second frame writes from addr 0.
- Reset mid-operation: assert reset while inject_clock=1 on byte 2 -> next edge gives inject_clock=0, IDLE, cpu_reset=1, byte_count=0. A following valid frame loads correctly.
